// File: rtl/rtc_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rtc_bus_ctrl
// Description : Multiplexed address/data RTC bus-cycle generator. Each request
//               becomes an address phase (WR strobe) followed by a data phase.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_bus_ctrl #(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 10,
    parameter int T_HOLD  = 2,
    parameter int T_GAP   = 10,
    parameter int CW      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    input  logic [7:0] bus_in,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d
);

    localparam logic [3:0] c_st_idle     = 4'd0;
    localparam logic [3:0] c_st_a_setup  = 4'd1;
    localparam logic [3:0] c_st_a_strobe = 4'd2;
    localparam logic [3:0] c_st_a_hold   = 4'd3;
    localparam logic [3:0] c_st_a_gap    = 4'd4;
    localparam logic [3:0] c_st_d_setup  = 4'd5;
    localparam logic [3:0] c_st_d_strobe = 4'd6;
    localparam logic [3:0] c_st_d_hold   = 4'd7;
    localparam logic [3:0] c_st_end_gap  = 4'd8;
    localparam logic [3:0] c_st_done     = 4'd9;

    localparam logic [CW-1:0] c_setup_last = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] c_pulse_last = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] c_hold_last  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] c_gap_last   = CW'(T_GAP - 1);
    localparam logic [CW-1:0] c_cnt_one    = CW'(1);

    logic [3:0]    r_state;
    logic [3:0]    w_state_nx;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nx;
    logic [CW-1:0] w_limit;
    logic          w_at_end;
    logic          r_we;
    logic [7:0]    r_wdata;
    logic          w_nx_addr_ph;
    logic          w_nx_data_ph;

    always_comb begin
        w_limit = '0;
        case (r_state)
            c_st_a_setup,  c_st_d_setup:  w_limit = c_setup_last;
            c_st_a_strobe, c_st_d_strobe: w_limit = c_pulse_last;
            c_st_a_hold,   c_st_d_hold:   w_limit = c_hold_last;
            c_st_a_gap,    c_st_end_gap:  w_limit = c_gap_last;
            default:                      w_limit = '0;
        endcase
    end

    assign w_at_end = (r_cnt == w_limit);

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            c_st_idle:     if (req)      w_state_nx = c_st_a_setup;
            c_st_a_setup:  if (w_at_end) w_state_nx = c_st_a_strobe;
            c_st_a_strobe: if (w_at_end) w_state_nx = c_st_a_hold;
            c_st_a_hold:   if (w_at_end) w_state_nx = c_st_a_gap;
            c_st_a_gap:    if (w_at_end) w_state_nx = c_st_d_setup;
            c_st_d_setup:  if (w_at_end) w_state_nx = c_st_d_strobe;
            c_st_d_strobe: if (w_at_end) w_state_nx = c_st_d_hold;
            c_st_d_hold:   if (w_at_end) w_state_nx = c_st_end_gap;
            c_st_end_gap:  if (w_at_end) w_state_nx = c_st_done;
            default:                     w_state_nx = c_st_idle;
        endcase
    end

    // The counter restarts at zero on every state change.
    assign w_cnt_nx = ((w_state_nx == r_state) && (r_state != c_st_idle)) ?
                      (r_cnt + c_cnt_one) : '0;

    assign w_nx_addr_ph = (w_state_nx == c_st_a_setup)  ||
                          (w_state_nx == c_st_a_strobe) ||
                          (w_state_nx == c_st_a_hold);
    assign w_nx_data_ph = (w_state_nx == c_st_d_setup)  ||
                          (w_state_nx == c_st_d_strobe) ||
                          (w_state_nx == c_st_d_hold);

    // Pins are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdata   <= '0;
            bus_out <= '0;
            bus_oe  <= 1'b0;
            cs_n    <= 1'b1;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
            a_d     <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            if ((r_state == c_st_idle) && req) begin
                r_we    <= we;
                r_wdata <= wdata;
                bus_out <= addr;
            end else if ((r_state == c_st_a_gap) && (w_state_nx == c_st_d_setup) && r_we) begin
                bus_out <= r_wdata;
            end
            if ((r_state == c_st_d_strobe) && (w_state_nx == c_st_d_hold) && !r_we) begin
                rdata <= bus_in;
            end
            busy   <= (w_state_nx != c_st_idle);
            done   <= (w_state_nx == c_st_done);
            cs_n   <= !(w_nx_addr_ph || w_nx_data_ph);
            a_d    <= w_nx_data_ph;
            bus_oe <= w_nx_addr_ph || (w_nx_data_ph && r_we);
            wr_n   <= !((w_state_nx == c_st_a_strobe) ||
                        ((w_state_nx == c_st_d_strobe) && r_we));
            rd_n   <= !((w_state_nx == c_st_d_strobe) && !r_we);
        end
    end

endmodule
`default_nettype wire
